// File: rtl/mt_ckpt.sv
// Rename map table with intra-group bypass, CDB-driven readiness and
// NUM_CKPT circular branch checkpoints that restore the whole map in one cycle.
module mt_ckpt #(
    parameter  int AR_W       = 5,
    parameter  int PR_W       = 7,
    parameter  int DISPATCH_W = 2,
    parameter  int CDB_W      = 4,
    parameter  int NUM_CKPT   = 4,
    localparam int CK_W       = $clog2(NUM_CKPT),
    localparam int DN_W       = $clog2(DISPATCH_W + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DN_W-1:0]            dispatch_num,
    input  logic [DISPATCH_W-1:0]      dest_valid,
    input  logic [DISPATCH_W*AR_W-1:0] dest_ar,
    input  logic [DISPATCH_W*PR_W-1:0] fl_pr,
    input  logic [DISPATCH_W*AR_W-1:0] src1_ar,
    input  logic [DISPATCH_W*AR_W-1:0] src2_ar,
    input  logic [CDB_W-1:0]           cdb_valid,
    input  logic [CDB_W*PR_W-1:0]      cdb_pr_tag,
    input  logic                       ckpt_take,
    input  logic                       br_recover,
    input  logic                       br_release,
    input  logic [CK_W-1:0]            br_ckpt_id,
    output logic [DISPATCH_W*PR_W-1:0] told,
    output logic [DISPATCH_W*PR_W-1:0] src1_pr,
    output logic [DISPATCH_W*PR_W-1:0] src2_pr,
    output logic [DISPATCH_W-1:0]      src1_ready,
    output logic [DISPATCH_W-1:0]      src2_ready,
    output logic [CK_W-1:0]            ckpt_id,
    output logic                       ckpt_full
);
    localparam int NUM_AR = 1 << AR_W;
    localparam int NUM_PR = 1 << PR_W;

    logic [PR_W-1:0]       map_reg    [NUM_AR];
    logic [PR_W-1:0]       map_next   [NUM_AR];
    logic [PR_W-1:0]       rename_map [NUM_AR];
    logic [PR_W-1:0]       ckpt_map   [NUM_CKPT][NUM_AR];
    logic [NUM_PR-1:0]     ready_reg, ready_next, ready_eff, cdb_set;
    logic [NUM_CKPT-1:0]   valid_reg, valid_next;
    logic [CK_W-1:0]       tail_reg, tail_next, span;
    logic [DISPATCH_W-1:0] alloc;
    logic                  recover_ok, take_ok;

    genvar gi;
    generate
        for (gi = 0; gi < DISPATCH_W; gi++) begin : g_alloc
            assign alloc[gi] = dest_valid[gi] && (DN_W'(gi) < dispatch_num);
        end
    endgenerate

    assign recover_ok = br_recover && valid_reg[br_ckpt_id];
    assign take_ok    = ckpt_take && !valid_reg[tail_reg] && !recover_ok;
    assign span       = tail_reg - br_ckpt_id;
    assign ckpt_id    = tail_reg;
    assign ckpt_full  = valid_reg[tail_reg];

    always_comb begin
        cdb_set = '0;
        for (int c = 0; c < CDB_W; c++)
            if (cdb_valid[c]) cdb_set[cdb_pr_tag[c*PR_W +: PR_W]] = 1'b1;
    end

    assign ready_eff = ready_reg | cdb_set;

    // Map after this cycle's group; later slots overwrite earlier ones.
    always_comb begin
        for (int a = 0; a < NUM_AR; a++) rename_map[a] = map_reg[a];
        for (int k = 0; k < DISPATCH_W; k++)
            if (alloc[k]) rename_map[dest_ar[k*AR_W +: AR_W]] = fl_pr[k*PR_W +: PR_W];
    end

    always_comb begin
        for (int a = 0; a < NUM_AR; a++)
            map_next[a] = recover_ok ? ckpt_map[br_ckpt_id][a] : rename_map[a];
    end

    // Allocation clears after the CDB sets, so a same-cycle alloc wins.
    always_comb begin
        ready_next = ready_eff;
        if (!recover_ok)
            for (int k = 0; k < DISPATCH_W; k++)
                if (alloc[k]) ready_next[fl_pr[k*PR_W +: PR_W]] = 1'b0;
    end

    // Recovery squashes br_ckpt_id..tail-1; span==0 only when full, i.e. all.
    always_comb begin
        valid_next = valid_reg;
        if (br_release) valid_next[br_ckpt_id] = 1'b0;
        if (recover_ok)
            for (int i = 0; i < NUM_CKPT; i++)
                if (span == '0 || (CK_W'(i) - br_ckpt_id) < span) valid_next[i] = 1'b0;
        if (take_ok) valid_next[tail_reg] = 1'b1;
    end

    always_comb begin
        tail_next = tail_reg;
        if (recover_ok)   tail_next = br_ckpt_id;
        else if (take_ok) tail_next = tail_reg + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < NUM_AR; a++) map_reg[a] <= PR_W'(a);
            ready_reg <= '1;
            valid_reg <= '0;
            tail_reg  <= '0;
        end else begin
            for (int a = 0; a < NUM_AR; a++) map_reg[a] <= map_next[a];
            ready_reg <= ready_next;
            valid_reg <= valid_next;
            tail_reg  <= tail_next;
        end
    end

    // Snapshot storage needs no reset: entries are only read while valid.
    always_ff @(posedge clock) begin
        if (take_ok)
            for (int a = 0; a < NUM_AR; a++) ckpt_map[tail_reg][a] <= rename_map[a];
    end

    generate
        for (gi = 0; gi < DISPATCH_W; gi++) begin : g_slot
            logic [AR_W-1:0] d_ar, a1, a2;
            logic [PR_W-1:0] told_k, s1_pr, s2_pr;
            logic            s1_rdy, s2_rdy;

            assign d_ar = dest_ar[gi*AR_W +: AR_W];
            assign a1   = src1_ar[gi*AR_W +: AR_W];
            assign a2   = src2_ar[gi*AR_W +: AR_W];

            always_comb begin
                told_k = map_reg[d_ar];
                s1_pr  = map_reg[a1];
                s2_pr  = map_reg[a2];
                s1_rdy = ready_eff[map_reg[a1]];
                s2_rdy = ready_eff[map_reg[a2]];
                for (int j = 0; j < gi; j++) begin
                    if (alloc[j]) begin
                        if (dest_ar[j*AR_W +: AR_W] == d_ar) told_k = fl_pr[j*PR_W +: PR_W];
                        if (dest_ar[j*AR_W +: AR_W] == a1) begin
                            s1_pr  = fl_pr[j*PR_W +: PR_W];
                            s1_rdy = 1'b0;
                        end
                        if (dest_ar[j*AR_W +: AR_W] == a2) begin
                            s2_pr  = fl_pr[j*PR_W +: PR_W];
                            s2_rdy = 1'b0;
                        end
                    end
                end
                if (!dest_valid[gi]) told_k = '0;
            end

            assign told[gi*PR_W +: PR_W]    = told_k;
            assign src1_pr[gi*PR_W +: PR_W] = s1_pr;
            assign src2_pr[gi*PR_W +: PR_W] = s2_pr;
            assign src1_ready[gi]           = s1_rdy;
            assign src2_ready[gi]           = s2_rdy;
        end
    endgenerate
endmodule
